ibus_responder: RTL and testbench

- Target-side end of the instruction bus; the core's fetch unit is the initiator.
- Accepts `ibus_req_t` from the core, holds one outstanding fetch, and returns 32-bit instruction words in `ibus_resp_t` after a programmable latency.
- Backed by a word-addressed instruction array with a bench/loader write port.
- Used as the fetch target in standalone simulation and for latency-stress runs of the pipeline.

---
 rtl/common_pkg.sv | 18 +
 rtl/ibus_rom_array.sv | 19 +
 rtl/ibus_responder.sv | 77 +++++++
 tb/tb_ibus_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// common: shared core types, instruction-bus structs and fetch-responder constants.
package common;
   typedef logic [63:0] u64;
   typedef logic [31:0] u32;
   typedef u64 word_t;
   typedef struct packed {
      logic  valid;
      word_t addr;
   } ibus_req_t;
   typedef struct packed {
      logic addr_ok;
      logic data_ok;
      u32   data;
   } ibus_resp_t;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} ibus_resp_state_t;
   localparam u32    RISCV_NOP = 32'h0000_0013;
   localparam word_t PCINIT    = 64'h8000_0000;
endpackage

// File: rtl/ibus_rom_array.sv
// ibus_rom_array: instruction word storage, one synchronous write port, one combinational read port.
module ibus_rom_array
   import common::*;
#(
   parameter  int MEM_WORDS = 65536,
   localparam int IW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] widx,
   input  u32            wdata,
   input  logic [IW-1:0] ridx,
   output u32            rdata
);
   u32 mem [MEM_WORDS];
   always_ff @(posedge clk)
      if (we) mem[widx] <= wdata;
   assign rdata = mem[ridx];
endmodule

// File: rtl/ibus_responder.sv
// ibus_responder: instruction-bus target, one outstanding fetch answered after LATENCY cycles.
// Define IBUS_RAND_DELAY_EN to add 0..3 LFSR-drawn extra wait cycles per fetch.
module ibus_responder
   import common::*;
#(
   parameter  int    MEM_WORDS = 65536,
   parameter  word_t BASE_ADDR = PCINIT,
   parameter  int    LATENCY   = 2,
   localparam int    IW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  ibus_req_t     ireq,
   output ibus_resp_t    iresp,
   output logic          fault,
   input  logic          load_en,
   input  logic [IW-1:0] load_idx,
   input  u32            load_data
);
   localparam word_t      END_ADDR   = BASE_ADDR + (word_t'(MEM_WORDS) << 2);
   localparam logic [4:0] BASE_WAITS = 5'(LATENCY - 1);
   ibus_resp_state_t state;
   word_t            req_addr;
   logic [4:0]       cnt, waits;
   logic [IW-1:0]    idx;
   u32               rdata;
   logic             bad, resp;
   assign bad   = |req_addr[1:0] || req_addr < BASE_ADDR || req_addr >= END_ADDR;
   assign idx   = IW'((req_addr - BASE_ADDR) >> 2);
   assign resp  = state == RESP;
   assign fault = resp && bad;
   assign iresp = '{addr_ok: reset && state == IDLE && ireq.valid,
                    data_ok: resp,
                    data:    resp ? (bad ? RISCV_NOP : rdata) : '0};
`ifdef IBUS_RAND_DELAY_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) lfsr <= 16'hACE1;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign waits = BASE_WAITS + 5'(lfsr[1:0]);
`else
   assign waits = BASE_WAITS;
`endif
   // waits = number of WAIT cycles between acceptance and RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         req_addr <= '0;
      end else begin
         case (state)
            IDLE: if (ireq.valid) begin
               req_addr <= ireq.addr;
               cnt      <= waits - 5'd1;
               state    <= waits == '0 ? RESP : WAIT;
            end
            WAIT: begin
               cnt   <= cnt - 5'd1;
               state <= cnt == '0 ? RESP : WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end
   ibus_rom_array #(.MEM_WORDS(MEM_WORDS)) u_array (
      .clk   (clk),
      .we    (load_en),
      .widx  (load_idx),
      .wdata (load_data),
      .ridx  (idx),
      .rdata (rdata)
   );
`ifndef SYNTHESIS
   hold_req: assert property (@(posedge clk) disable iff (!reset)
      state == WAIT |-> ireq.valid && ireq.addr == req_addr);
`endif
endmodule

// File: tb/tb_ibus_responder.sv
// tb_ibus_responder: directed and randomized fetches checked against a shadow-array reference model.
module tb_ibus_responder;
   import common::*;
   localparam int    MW   = 65536;
   localparam int    L    = 2;
   localparam word_t BASE = PCINIT;
   localparam word_t TOP  = BASE + 64'(MW) * 4;
   logic        clk, reset, fault, load_en;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic [15:0] load_idx;
   u32          load_data;
   u32          shadow [int];
   int          n_cmp, n_bad;
   ibus_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .ireq      (ireq),
      .iresp     (iresp),
      .fault     (fault),
      .load_en   (load_en),
      .load_idx  (load_idx),
      .load_data (load_data)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // one cycle: drive at negedge, sample 2 time units later
   task automatic cyc(logic v, word_t a);
      @(negedge clk);
      load_en    = 0;
      ireq.valid = v;
      ireq.addr  = a;
      #2;
   endtask
   task automatic load(int idx, u32 d);
      cyc(0, '0);
      load_en   = 1;
      load_idx  = 16'(idx);
      load_data = d;
      shadow[idx] = d;
      check("idle_addr_ok", iresp.addr_ok, 0);
   endtask
   task automatic idle_cycle();
      cyc(0, '0);
      check("idle_data_ok", iresp.data_ok, 0);
      check("idle_data", iresp.data, 0);
   endtask
   task automatic fetch(word_t a, bit collide, u32 nd);
      bit flt;
      int idx;
      u32 exp;
      flt = a[1:0] != 0 || a < BASE || a >= TOP;
      idx = int'(((a - BASE) >> 2) % 64'(MW));
      cyc(1, a);
      check("accept_addr_ok", iresp.addr_ok, 1);
      check("accept_data_ok", iresp.data_ok, 0);
      for (int k = 1; k < L; k++) begin
         cyc(1, a);
         check("wait_addr_ok", iresp.addr_ok, 0);
         check("wait_data_ok", iresp.data_ok, 0);
         check("wait_data", iresp.data, 0);
      end
      cyc(1, a);
      exp = flt ? RISCV_NOP : shadow[idx];
      if (collide && !flt) begin
         load_en   = 1;
         load_idx  = 16'(idx);
         load_data = nd;
      end
      #1;
      check("resp_data_ok", iresp.data_ok, 1);
      check("resp_addr_ok", iresp.addr_ok, 0);
      check("resp_data", iresp.data, exp);
      check("resp_fault", fault, flt);
      if (collide && !flt) shadow[idx] = nd;
   endtask
   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset      = 0;
      load_en    = 0;
      load_idx   = 0;
      load_data  = 0;
      ireq.valid = 1;
      ireq.addr  = BASE;
      #3;
      check("rst_addr_ok", iresp.addr_ok, 0);
      check("rst_data_ok", iresp.data_ok, 0);
      check("rst_data", iresp.data, 0);
      check("rst_fault", fault, 0);
      repeat (2) @(negedge clk);
      ireq.valid = 0;
      reset = 1;
      for (int i = 2; i < 64; i++) load(i, $urandom);
      load(MW - 1, $urandom);
      load(0, 32'h0010_0093);
      load(1, 32'h0000_0513);
      idle_cycle();
      fetch(BASE, 0, 0);
      fetch(BASE + 4, 0, 0);
      idle_cycle();
      fetch(BASE + 2, 0, 0);
      fetch(64'h7FFF_FFFC, 0, 0);
      fetch(TOP, 0, 0);
      fetch(TOP - 4, 0, 0);
      fetch(64'hFFFF_FFFF_8000_0000, 0, 0);
      idle_cycle();
      fetch(BASE, 1, 32'hDEAD_BEEF);
      fetch(BASE, 0, 0);
      check("refetch_model", shadow[0], 32'hDEAD_BEEF);
      cyc(1, BASE);
      check("mid_accept", iresp.addr_ok, 1);
      cyc(1, BASE);
      check("mid_wait_data_ok", iresp.data_ok, 0);
      reset = 0;
      #1;
      check("mid_rst_addr_ok", iresp.addr_ok, 0);
      check("mid_rst_data_ok", iresp.data_ok, 0);
      check("mid_rst_data", iresp.data, 0);
      check("mid_rst_fault", fault, 0);
      repeat (2) cyc(0, '0);
      @(negedge clk);
      reset = 1;
      repeat (4) begin
         idle_cycle();
         check("post_rst_fault", fault, 0);
      end
      fetch(BASE + 4, 0, 0);
      for (int n = 0; n < 60; n++) begin
         int r;
         word_t a;
         r = $urandom_range(0, 9);
         if (r < 6)       a = BASE + 64'($urandom_range(0, 63)) * 4;
         else if (r == 6) a = BASE + 64'($urandom_range(0, 63)) * 4 + 64'($urandom_range(1, 3));
         else if (r == 7) a = BASE - 64'($urandom_range(1, 1000)) * 4;
         else if (r == 8) a = TOP + 64'($urandom_range(0, 1000)) * 4;
         else             a = TOP - 4;
         fetch(a, $urandom_range(0, 3) == 0, $urandom);
         repeat ($urandom_range(0, 2)) begin
            idle_cycle();
            if ($urandom_range(0, 1) == 1) begin
               int i;
               i = $urandom_range(0, 63);
               load_en   = 1;
               load_idx  = 16'(i);
               load_data = $urandom;
               shadow[i] = load_data;
            end
         end
      end
      idle_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
